cond_logic: RTL

Conditional-execution unit for the multicycle ARM-subset datapath. It consumes the 4-bit ALUFlags vector ({N,Z,C,V}) produced by the ALU and holds the architectural status flags. It evaluates the instruction's 4-bit condition field against those flags and gates the controller's write-enables (PC, register file, memory, flags), so a failed-condition instruction is squashed without changing state. It sits between the main controller FSM and the datapath, on the consuming end of the ALU flag interface.

---
 rtl/cond_logic.sv | 77 +++++++
 1 files changed

// File: rtl/cond_logic.sv
// Conditional-execution unit: stores the NZCV status flags, evaluates the
// instruction condition field and squashes the controller's write-enables.
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [3:0] r_flags;
  logic       r_cond_ex_d;
  logic [1:0] w_flag_write;
  logic       w_n, w_z, w_c, w_v;
  logic       w_cond_ex;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Evaluated from the stored flags only, so a flag-setting instruction
  // sees the pre-update state in its own cycle.
  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = w_n ~^ w_v;
      4'b1011: w_cond_ex = w_n ^ w_v;
      4'b1100: w_cond_ex = ~w_z & (w_n ~^ w_v);
      4'b1101: w_cond_ex = w_z | (w_n ^ w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  assign w_flag_write = FlagW & {2{w_cond_ex}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags     <= 4'b0000;
      r_cond_ex_d <= 1'b0;
    end else begin
      if (w_flag_write[1]) r_flags[3:2] <= ALUFlags[3:2];
      if (w_flag_write[0]) r_flags[1:0] <= ALUFlags[1:0];
      r_cond_ex_d <= w_cond_ex;
    end
  end

  // The delayed decision gates writeback/memory states of the multicycle FSM;
  // fetch (NextPC) is never squashed.
  assign PCWrite  = (PCS & r_cond_ex_d) | NextPC;
  assign RegWrite = RegW & r_cond_ex_d & ~NoWrite;
  assign MemWrite = MemW & r_cond_ex_d;
  assign Flags    = r_flags;
  assign CondEx   = w_cond_ex;

endmodule
